// File: rtl/flash_stream_reader.sv
// flash_stream_reader: sequential byte-mode reader for a parallel CFI flash.
// Fetches byte_len bytes from base_addr into a show-ahead FIFO and delivers them
// on a valid/ready byte stream. This block is the only master of the flash bus.
// Optional feature macro: FLASH_RD_CHECKSUM_EN adds a 16-bit running sum of the
// bytes delivered on the stream.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, flush               run request / abort (flush wins)
//   base_addr, byte_len        run parameters, sampled on an accepted start
//   out_data/out_valid/out_ready  byte stream to the parser
//   busy, done                 run status, done pulses after the last FIFO write
//   flash_*                    flash address, data and control pins
//   checksum                   (FLASH_RD_CHECKSUM_EN only) sum of delivered bytes
module flash_stream_reader #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned RST_CYCLES  = 25,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [21:0] base_addr,
    input  logic [21:0] byte_len,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [21:0] flash_addr,
    input  logic [7:0]  flash_data,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
`ifdef FLASH_RD_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic        flash_rst_n
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CMAX  = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int unsigned CW    = $clog2(CMAX + 1);

    localparam logic [2:0] S_FRST    = 3'd0;
    localparam logic [2:0] S_FREC    = 3'd1;
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_SETUP   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [21:0]   rem, rem_nxt;
    logic [21:0]   addr_nxt;
    logic          ce_nxt, busy_nxt, done_nxt, frst_nxt;
    logic          push, fifo_clr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_nxt;
    logic          full, pop;

    assign flash_we_n = 1'b1;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = out_valid & out_ready;
    assign out_data   = mem[rptr];

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FRST;
            cnt         <= '0;
            rem         <= '0;
            flash_addr  <= '0;
            flash_ce_n  <= 1'b1;
            flash_oe_n  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            flash_rst_n <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rem         <= rem_nxt;
            flash_addr  <= addr_nxt;
            flash_ce_n  <= ce_nxt;
            flash_oe_n  <= ce_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            flash_rst_n <= frst_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        addr_nxt  = flash_addr;
        ce_nxt    = flash_ce_n;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        frst_nxt  = flash_rst_n;
        push      = 1'b0;
        fifo_clr  = 1'b0;
        case (state)
            S_FRST: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_nxt = S_FREC;
                    cnt_nxt   = '0;
                    frst_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_FREC: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (start) begin
                    addr_nxt = base_addr;
                    rem_nxt  = byte_len;
                    if (byte_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        busy_nxt  = 1'b1;
                        state_nxt = S_SETUP;
                    end
                end
            end
            // Only one read is ever in flight, so checking for a free slot here
            // guarantees the later push never overflows.
            S_SETUP: begin
                if (!full) begin
                    ce_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CW'(WAIT_CYCLES - 1)) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // Address advances on the same edge CE#/OE# rise, never while low.
            S_CAPTURE: begin
                push      = 1'b1;
                addr_nxt  = flash_addr + 1'b1;
                rem_nxt   = rem - 1'b1;
                ce_nxt    = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (rem == '0) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_SETUP;
                end
            end
            default: begin
                state_nxt = S_FRST;
                cnt_nxt   = '0;
                frst_nxt  = 1'b0;
            end
        endcase
        // Flush overrides everything outside the flash reset sequence.
        if (flush && (state != S_FRST) && (state != S_FREC)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            rem_nxt   = rem;
            addr_nxt  = flash_addr;
            ce_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            push      = 1'b0;
            fifo_clr  = 1'b1;
        end
    end

    // FIFO occupancy
    always_comb begin
        count_nxt = count;
        if (fifo_clr) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // FIFO pointers and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (fifo_clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
            end
        end
    end

    // FIFO storage: flash_data is sampled here at the end of CAPTURE
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= flash_data;
    end

`ifdef FLASH_RD_CHECKSUM_EN
    // Running sum of delivered bytes, restarted by each accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if ((state == S_IDLE) && start && !flush) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + {8'h00, out_data};
        end
    end
`endif

endmodule

// File: tb/tb_flash_stream_reader.sv
// tb_flash_stream_reader: self-checking bench for flash_stream_reader.
// A behavioural flash returns a fixed function of the address; expected bytes and
// addresses are queued when a run is started and popped as the DUT produces them.
module tb_flash_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [21:0] base_addr;
    logic [21:0] byte_len;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [21:0] flash_addr;
    logic [7:0]  flash_data;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_rst_n;
`ifdef FLASH_RD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    flash_stream_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .base_addr   (base_addr),
        .byte_len    (byte_len),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .flash_addr  (flash_addr),
        .flash_data  (flash_data),
        .flash_ce_n  (flash_ce_n),
        .flash_oe_n  (flash_oe_n),
        .flash_we_n  (flash_we_n),
`ifdef FLASH_RD_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .flash_rst_n (flash_rst_n)
    );

    always #5 clk = ~clk;

    // Flash contents: a few hand-picked bytes, otherwise a hash of the address.
    function automatic logic [7:0] flash_byte(input logic [21:0] a);
        case (a)
            22'h155550: flash_byte = 8'h01;
            22'h155551: flash_byte = 8'hFF;
            22'h155552: flash_byte = 8'h80;
            default:    flash_byte = a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
        endcase
    endfunction

    assign flash_data = flash_byte(flash_addr);

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rx_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [21:0] addr_q[$];
    int          fall_t[$];
    logic        prev_ce = 1'b1;
    logic [21:0] held_addr = '0;

    typedef struct {
        logic [21:0] base;
        logic [21:0] len;
        logic        rdy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output scoreboard and flash-bus monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) check("rx_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                else                   check("rx_byte", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (prev_ce && !flash_ce_n) begin
                fall_t.push_back(cyc);
                held_addr = flash_addr;
                if (addr_q.size() == 0) check("rd_unexpected", 32'(flash_addr), 32'hFFFF_FFFF);
                else                    check("rd_addr", 32'(flash_addr), 32'(addr_q.pop_front()));
            end else if (!flash_ce_n && flash_addr !== held_addr) begin
                check("addr_stable", 32'(flash_addr), 32'(held_addr));
            end
            if (flash_oe_n !== flash_ce_n) check("oe_eq_ce", 32'(flash_oe_n), 32'(flash_ce_n));
            if (done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            prev_ce = flash_ce_n;
        end else begin
            prev_ce = 1'b1;
        end
    end

    // Start a run, queue its expectations and wait for its done pulse.
    task automatic run(input logic [21:0] base, input logic [21:0] len, input logic rdy);
        int n;
        out_ready = rdy;
        fall_t.delete();
        done_cnt = 0;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(flash_byte(22'(base + 22'(i))));
            addr_q.push_back(22'(base + 22'(i)));
        end
        start     = 1'b1;
        base_addr = base;
        byte_len  = len;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("rx_left", 32'(exp_q.size()), 32'd0);
        check("addr_left", 32'(addr_q.size()), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   n;

        vecs[0] = '{base: 22'h000100, len: 22'd4, rdy: 1'b1};
        vecs[1] = '{base: 22'h3FFFFE, len: 22'd3, rdy: 1'b1};
        vecs[2] = '{base: 22'h0ABCDE, len: 22'd0, rdy: 1'b1};
        vecs[3] = '{base: 22'h000200, len: 22'd9, rdy: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        byte_len  = '0;
        repeat (3) tick();
        check("rst_ce_n", 32'(flash_ce_n), 32'd1);
        check("rst_oe_n", 32'(flash_oe_n), 32'd1);
        check("rst_we_n", 32'(flash_we_n), 32'd1);
        check("rst_frst_n", 32'(flash_rst_n), 32'd0);
        check("rst_addr", 32'(flash_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Flash reset pulse length, with starts that must be ignored
        rst_n     = 1'b1;
        start     = 1'b1;
        base_addr = 22'h000055;
        byte_len  = 22'd2;
        n = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
        end while (flash_rst_n !== 1'b1 && n < 200);
        check("frst_len", 32'(n), 32'd25);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_reads", 32'(fall_t.size()), 32'd0);
        check("ign_done", 32'(done_cnt), 32'd0);

        // flush + start together: start must be ignored
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check("fs_busy", 32'(busy), 32'd0);
        check("fs_done", 32'(done_cnt), 32'd0);

        // Table-driven runs
        for (int v = 0; v < 4; v++) begin
            run(vecs[v].base, vecs[v].len, vecs[v].rdy);
            repeat (4) tick();
            check("run_done_once", 32'(done_cnt), 32'd1);
            check("run_reads", 32'(fall_t.size()), 32'(vecs[v].len));
            for (int i = 1; i < fall_t.size(); i++)
                check("run_period", 32'(fall_t[i] - fall_t[i-1]), 32'd8);
            drain();
        end

        // Back-pressure: 16 bytes fill the FIFO, then the reader stalls
        rx_cnt = 0;
        out_ready = 1'b0;
        fall_t.delete();
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(flash_byte(22'(22'h001000 + 22'(i))));
            addr_q.push_back(22'(22'h001000 + 22'(i)));
        end
        start     = 1'b1;
        base_addr = 22'h001000;
        byte_len  = 22'd20;
        tick();
        start = 1'b0;
        repeat (170) tick();
        check("stall_reads", 32'(fall_t.size()), 32'd16);
        check("stall_ce_n", 32'(flash_ce_n), 32'd1);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            tick();
            n++;
        end
        check("stall_done", 32'(done_cnt), 32'd1);
        drain();
        check("stall_rx_cnt", 32'(rx_cnt), 32'd20);

        // Flush during the wait of the second byte, then an immediate new run
        out_ready = 1'b0;
        fall_t.delete();
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(flash_byte(22'(22'h002000 + 22'(i))));
            addr_q.push_back(22'(22'h002000 + 22'(i)));
        end
        start     = 1'b1;
        base_addr = 22'h002000;
        byte_len  = 22'd5;
        tick();
        start = 1'b0;
        n = 0;
        while (fall_t.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("fl_reach_b2", 32'(fall_t.size()), 32'd2);
        check("fl_ce_low", 32'(flash_ce_n), 32'd0);
        flush = 1'b1;
        exp_q.delete();
        addr_q.delete();
        tick();
        flush = 1'b0;
        check("fl_ce_n", 32'(flash_ce_n), 32'd1);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_no_done", 32'(done_cnt), 32'd0);
        run(22'h003000, 22'd3, 1'b1);
        repeat (4) tick();
        check("fl_next_done", 32'(done_cnt), 32'd1);
        drain();

        // Reset in the middle of a run
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) addr_q.push_back(22'(22'h004000 + 22'(i)));
        start     = 1'b1;
        base_addr = 22'h004000;
        byte_len  = 22'd8;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mr_ce_n", 32'(flash_ce_n), 32'd1);
        check("mr_frst_n", 32'(flash_rst_n), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_addr", 32'(flash_addr), 32'd0);
        addr_q.delete();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("mr_frst_done", 32'(flash_rst_n), 32'd1);

`ifdef FLASH_RD_CHECKSUM_EN
        run(22'h155550, 22'd3, 1'b1);
        drain();
        repeat (2) tick();
        check("checksum", 32'(checksum), 32'h0180);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
